// File: rtl/ofm_wr_ctrl.sv
// Output-feature-map write-back controller.
// Takes un-stallable pixel beats from the accumulate/bias/ReLU stage, buffers them in a
// small FIFO, and writes them to OFM SRAM over a valid/ready port. Addresses follow a
// channel-group-major layout.
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   i_start                    pulse: latch layer config, begin pass (IDLE only)
//   i_fm_col/i_fm_row/i_ch_grp layer geometry (columns, rows, 32-channel groups)
//   i_layer1                   1: all 32 channels valid, 0: low 16 only
//   i_addr_base                OFM base word address
//   i_acc_data/i_acc_valid     incoming pixel beat
//   o_mem_*/i_mem_ready        SRAM write port (valid/ready)
//   o_busy, o_done             pass in progress / one-cycle completion pulse
//   o_err_ovf, o_err_unexp     sticky errors: buffer overflow / beat outside a pass
module ofm_wr_ctrl #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [15:0]         i_fm_col,
  input  logic [15:0]         i_fm_row,
  input  logic [7:0]          i_ch_grp,
  input  logic                i_layer1,
  input  logic [ADDR_W-1:0]   i_addr_base,
  input  logic [DATA_W-1:0]   i_acc_data,
  input  logic                i_acc_valid,
  output logic                o_mem_wr_en,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_ovf,
  output logic                o_err_unexp
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e state_q, state_d;

  logic              start_cfg;
  logic [15:0]       col_q, row_q;
  logic [7:0]        grp_q;
  logic              layer1_q;
  logic [ADDR_W-1:0] base_q, plane_sz_q, plane_prod;

  logic [15:0]       col_cnt_q, row_cnt_q;
  logic [7:0]        grp_cnt_q;
  logic [ADDR_W-1:0] plane_off_q, row_off_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full;

  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q, load_data;
  logic [MaskW-1:0]  out_mask_q;

  logic accept, load, push_req, pop, bypass, fifo_wr, ovf_evt, unexp_evt, last_beat;

  // Plane stride is multiplied once per layer at start, never per beat.
  assign plane_prod = ADDR_W'(i_fm_row) * ADDR_W'(i_fm_col);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign accept    = out_vld_q & i_mem_ready;
  assign load      = ~out_vld_q | accept;
  assign push_req  = i_acc_valid & (state_q == StRun);
  assign pop       = load & ~fifo_empty;
  // An empty path forwards the beat straight to the output stage: one-cycle latency.
  assign bypass    = load & fifo_empty & push_req;
  assign fifo_wr   = push_req & ~bypass & (~fifo_full | pop);
  assign ovf_evt   = push_req & fifo_full & ~pop;
  assign unexp_evt = i_acc_valid & (state_q != StRun);

  assign last_beat = (col_cnt_q == col_q - 16'd1) && (grp_cnt_q == grp_q - 8'd1) &&
                     (row_cnt_q == row_q - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_cfg = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          start_cfg = 1'b1;
          if (i_fm_col == '0 || i_fm_row == '0 || i_ch_grp == '0) state_d = StDone;
          else                                                    state_d = StRun;
        end
      end
      StRun: begin
        o_busy = 1'b1;
        if (accept && last_beat) state_d = StDone;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      grp_q      <= '0;
      layer1_q   <= 1'b0;
      base_q     <= '0;
      plane_sz_q <= '0;
    end else if (start_cfg) begin
      col_q      <= i_fm_col;
      row_q      <= i_fm_row;
      grp_q      <= i_ch_grp;
      layer1_q   <= i_layer1;
      base_q     <= i_addr_base;
      plane_sz_q <= plane_prod;
    end
  end

  // Column fastest, then channel group, then row; advance only on an accepted write.
  always_ff @(posedge clk) begin
    if (!rst_n || start_cfg) begin
      col_cnt_q   <= '0;
      grp_cnt_q   <= '0;
      row_cnt_q   <= '0;
      plane_off_q <= '0;
      row_off_q   <= '0;
    end else if (accept) begin
      if (col_cnt_q == col_q - 16'd1) begin
        col_cnt_q <= '0;
        if (grp_cnt_q == grp_q - 8'd1) begin
          grp_cnt_q   <= '0;
          plane_off_q <= '0;
          row_cnt_q   <= row_cnt_q + 16'd1;
          row_off_q   <= row_off_q + ADDR_W'(col_q);
        end else begin
          grp_cnt_q   <= grp_cnt_q + 8'd1;
          plane_off_q <= plane_off_q + plane_sz_q;
        end
      end else begin
        col_cnt_q <= col_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q[PtrW-1:0]] <= i_acc_data;
  end

  always_comb begin
    load_data = pop ? fifo_mem[rd_ptr_q[PtrW-1:0]] : i_acc_data;
    if (!layer1_q) load_data[DATA_W-1:DATA_W/2] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
    end else if (load) begin
      out_vld_q <= pop | bypass;
      if (pop || bypass) begin
        out_data_q <= load_data;
        out_mask_q <= layer1_q ? {MaskW{1'b1}} : {{(MaskW/2){1'b0}}, {(MaskW/2){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start_cfg) begin
      o_err_ovf   <= 1'b0;
      o_err_unexp <= 1'b0;
    end else begin
      if (ovf_evt)   o_err_ovf   <= 1'b1;
      if (unexp_evt) o_err_unexp <= 1'b1;
    end
  end

  assign o_mem_wr_en = out_vld_q;
  assign o_mem_wdata = out_data_q;
  assign o_mem_wmask = out_mask_q;
  // Counters only move on accept, so the address holds while a write is stalled.
  assign o_mem_addr  = base_q + plane_off_q + row_off_q + ADDR_W'(col_cnt_q);

endmodule

// File: tb/tb_ofm_wr_ctrl.sv
module tb_ofm_wr_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [15:0]  i_fm_col = '0, i_fm_row = '0;
  logic [7:0]   i_ch_grp = '0;
  logic         i_layer1 = 1'b0;
  logic [15:0]  i_addr_base = '0;
  logic [255:0] i_acc_data = '0;
  logic         i_acc_valid = 1'b0;
  logic         o_mem_wr_en;
  logic [15:0]  o_mem_addr;
  logic [255:0] o_mem_wdata;
  logic [31:0]  o_mem_wmask;
  logic         i_mem_ready = 1'b0;
  logic         o_busy, o_done, o_err_ovf, o_err_unexp;

  ofm_wr_ctrl #(.DATA_W(256), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_fm_col    (i_fm_col),
    .i_fm_row    (i_fm_row),
    .i_ch_grp    (i_ch_grp),
    .i_layer1    (i_layer1),
    .i_addr_base (i_addr_base),
    .i_acc_data  (i_acc_data),
    .i_acc_valid (i_acc_valid),
    .o_mem_wr_en (o_mem_wr_en),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wmask (o_mem_wmask),
    .i_mem_ready (i_mem_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err_ovf   (o_err_ovf),
    .o_err_unexp (o_err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic [255:0] data;
    logic [31:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   writes = 0;
  int   last_acc_cyc = 0;
  int   done_cnt = 0;
  bit   busy_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted write must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && o_mem_wr_en && i_mem_ready) begin
      exp_t e;
      writes++;
      last_acc_cyc = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, none required", o_mem_addr,
                 o_mem_wdata);
      end else begin
        e = sb.pop_front();
        if (o_mem_addr !== e.addr || o_mem_wdata !== e.data || o_mem_wmask !== e.mask) begin
          bad++;
          $display("FAIL write: got addr=%h mask=%h data=%h, want addr=%h mask=%h data=%h",
                   o_mem_addr, o_mem_wmask, o_mem_wdata, e.addr, e.mask, e.data);
        end
      end
    end
    if (o_done) done_cnt++;
    if (o_busy) busy_seen = 1'b1;
  end

  function automatic logic [255:0] rand256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Independent address model: closed-form, beat index n in col/grp/row order.
  function automatic logic [15:0] exp_addr(int n, int col, int row, int grp, int base);
    int c, g, r;
    c = n % col;
    g = (n / col) % grp;
    r = n / (col * grp);
    return 16'(base + g * row * col + r * col + c);
  endfunction

  task automatic do_start(input int col, input int row, input int grp, input bit l1,
                          input int base);
    @(posedge clk); #1;
    i_fm_col = 16'(col); i_fm_row = 16'(row); i_ch_grp = 8'(grp);
    i_layer1 = l1; i_addr_base = 16'(base); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic drive_layer(input int col, input int row, input int grp, input bit l1,
                             input int base, input bit all_ff);
    logic [255:0] d;
    exp_t e;
    for (int n = 0; n < col * row * grp; n++) begin
      @(posedge clk); #1;
      d = all_ff ? {256{1'b1}} : rand256();
      i_acc_data = d; i_acc_valid = 1'b1;
      e.addr = exp_addr(n, col, row, grp, base);
      e.data = l1 ? d : {128'h0, d[127:0]};
      e.mask = l1 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      sb.push_back(e);
    end
    @(posedge clk); #1 i_acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({o_mem_wr_en, o_mem_addr, o_mem_wdata, o_mem_wmask, o_busy, o_done, o_err_ovf,
         o_err_unexp} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b addr=%h mask=%h busy=%b done=%b, want all 0",
               o_mem_wr_en, o_mem_addr, o_mem_wmask, o_busy, o_done);
    end
  endtask

  task automatic test_back_to_back(input bit l1, input bit all_ff, input string name);
    int w0, k;
    bit seen;
    i_mem_ready = 1'b1;
    w0 = writes;
    do_start(4, 2, 2, l1, 'h100);
    drive_layer(4, 2, 2, l1, 'h100, all_ff);
    seen = 1'b0;
    for (k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout: no o_done within 40 cycles", name);
    end
    total++;
    if (writes - w0 != 16) begin
      bad++;
      $display("FAIL %s_write_count: got %0d want 16", name, writes - w0);
    end
    total++;
    if (cyc - last_acc_cyc != 1) begin
      bad++;
      $display("FAIL %s_done_latency: got %0d cycles after last write, want 1", name,
               cyc - last_acc_cyc);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes: %0d beats never written, want 0", name, sb.size());
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_after_done: done=%b busy=%b want 0 0", name, o_done, o_busy);
    end
  endtask

  task automatic test_overflow();
    logic [255:0] d0, d;
    exp_t e;
    int w0;
    i_mem_ready = 1'b0;
    do_start(8, 1, 1, 1'b1, 'h2000);
    w0 = writes;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      d = rand256();
      if (n == 0) d0 = d;
      i_acc_data = d; i_acc_valid = 1'b1;
      e.addr = 16'h2000 + 16'(n); e.data = d; e.mask = 32'hFFFF_FFFF;
      sb.push_back(e);
    end
    @(posedge clk); #1 i_acc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 16'h2000 || o_mem_wdata !== d0) begin
        bad++;
        $display("FAIL stall_hold: wr=%b addr=%h want 1 2000, data stable=%b",
                 o_mem_wr_en, o_mem_addr, o_mem_wdata === d0);
      end
    end
    total++;
    if (o_err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: got %b want 0", o_err_ovf);
    end
    @(posedge clk); #1 i_acc_data = rand256(); i_acc_valid = 1'b1;
    @(posedge clk); #1 i_acc_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got %b want 1", o_err_ovf);
    end
    i_mem_ready = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (writes - w0 != 5 || sb.size() != 0) begin
      bad++;
      $display("FAIL ovf_drain: got %0d writes want 5 (pending %0d)", writes - w0, sb.size());
    end
    total++;
    if (o_busy !== 1'b1 || o_err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_still_run: busy=%b ovf=%b want 1 1", o_busy, o_err_ovf);
    end
    pulse_reset();
  endtask

  task automatic test_zero_dim();
    int w0, d0, k;
    bit seen;
    i_mem_ready = 1'b1;
    w0 = writes; d0 = done_cnt;
    @(negedge clk) busy_seen = 1'b0;
    do_start(0, 3, 2, 1'b1, 'h55);
    seen = 1'b0;
    for (k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    total++;
    if (!seen || k > 2) begin
      bad++;
      $display("FAIL zero_done: seen=%b after %0d waits, want seen within 2", seen, k);
    end
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 != 1 || writes != w0 || busy_seen) begin
      bad++;
      $display("FAIL zero_side_effects: dones=%0d writes=%0d busy_seen=%b, want 1 0 0",
               done_cnt - d0, writes - w0, busy_seen);
    end
  endtask

  task automatic test_unexpected();
    int w0, k;
    bit seen;
    w0 = writes;
    @(posedge clk); #1 i_acc_data = rand256(); i_acc_valid = 1'b1;
    @(posedge clk); #1 i_acc_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_err_unexp !== 1'b1 || o_mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL unexp_idle: unexp=%b wr=%b want 1 0", o_err_unexp, o_mem_wr_en);
    end
    do_start(1, 1, 1, 1'b1, 'h40);
    @(negedge clk);
    total++;
    if (o_err_unexp !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL unexp_clear: unexp=%b busy=%b want 0 1", o_err_unexp, o_busy);
    end
    drive_layer(1, 1, 1, 1'b1, 'h40, 1'b0);
    seen = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    total++;
    if (!seen || writes - w0 != 1) begin
      bad++;
      $display("FAIL single_beat: done=%b writes=%0d want 1 1", seen, writes - w0);
    end
  endtask

  task automatic test_reset_mid_run();
    int w0, d0;
    i_mem_ready = 1'b0;
    do_start(4, 2, 2, 1'b1, 'h300);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1 i_acc_data = rand256(); i_acc_valid = 1'b1;
    end
    @(posedge clk); #1 i_acc_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    total++;
    if ({o_mem_wr_en, o_mem_addr, o_mem_wdata, o_mem_wmask, o_busy, o_done, o_err_ovf,
         o_err_unexp} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: wr=%b addr=%h mask=%h busy=%b, want all 0",
               o_mem_wr_en, o_mem_addr, o_mem_wmask, o_busy);
    end
    i_mem_ready = 1'b1;
    w0 = writes; d0 = done_cnt;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1 i_acc_data = rand256(); i_acc_valid = 1'b1;
    end
    @(posedge clk); #1 i_acc_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (o_err_unexp !== 1'b1 || writes != w0 || done_cnt != d0) begin
      bad++;
      $display("FAIL midrun_after: unexp=%b writes=%0d dones=%0d want 1 0 0", o_err_unexp,
               writes - w0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back(1'b1, 1'b0, "layer1");
    test_back_to_back(1'b0, 1'b1, "layer0");
    test_overflow();
    test_zero_dim();
    test_unexpected();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
